fsm_frame_tx: RTL
=================

Name: fsm_frame_tx

Overview:
Transmit-side counterpart of the RF wake/shift synchroniser. On a start request it does four things in order:
- drives a wake-up pulse on rfout;
- waits a programmable gap;
- serialises a parallel word on sdo, framed by sh_en;
- drops sh_en to generate the falling edge that returns the far-end synchroniser to IDLE.

It sits between the digital control core (parallel word plus start) and the RF/serial pads.

Parameters:
- DATA_W, 8, payload bits per frame (legal range 1..32).
- PRE_LEN, 2, number of cycles rfout is held high (legal value >= 1).
- GAP_LEN, 1, idle cycles between the wake pulse and the first data bit (legal value >= 0; 0 skips the GAP state).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  frame request; sampled only in IDLE.
- din  in  DATA_W  payload; captured on the accepted start edge.
- busy  out  1  high in every state except IDLE.
- rfout  out  1  wake-up pulse to the RF path.
- sh_en  out  1  shift-enable frame; high exactly while data bits are on sdo.
- sdo  out  1  serial data, MSB first.
- done  out  1  single-cycle pulse marking end of frame.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; busy, rfout, sh_en, sdo and done all 0; shift register and counter cleared.
- Reset asserted mid-frame aborts immediately and asynchronously. sh_en may therefore fall without a TAIL cycle; this is acceptable because the receiver is reset from the same domain.
- All outputs are registered and decoded from the state / shift register. There is no combinational path from start or din to any output.
- States: IDLE, PRE, GAP, SHIFT, TAIL.
- IDLE:
  - start=1 at a posedge loads din into the shift register, loads the counter with PRE_LEN-1, and moves to PRE.
  - start=0 holds IDLE.
- PRE:
  - rfout=1.
  - When the counter reaches 0: go to GAP if GAP_LEN>0 (counter=GAP_LEN-1), otherwise go to SHIFT (counter=DATA_W-1).
- GAP:
  - All outputs except busy are 0.
  - When the counter reaches 0: go to SHIFT (counter=DATA_W-1).
- SHIFT:
  - sh_en=1; sdo = shift-register MSB.
  - The register shifts left, filling with 0, each cycle.
  - When the counter reaches 0: go to TAIL.
- TAIL:
  - Exactly one cycle with sh_en=0, sdo=0, done=1.
  - Then go to IDLE unconditionally.
- Latency and duration: first PRE cycle is one clock after the accepted start. busy is high for exactly PRE_LEN+GAP_LEN+DATA_W+1 cycles.
- start while busy is ignored: no queuing and no din capture. This includes start in the TAIL/done cycle.
- A start sampled in the first IDLE cycle after TAIL is accepted, giving back-to-back frames with a one-cycle IDLE gap.
- din changes after capture have no effect on the frame in flight.
- Counter width is $clog2(max(PRE_LEN,GAP_LEN,DATA_W)+1). The counter only decrements and never wraps, because every state reloads it on entry.
- rfout and sh_en are never high in the same cycle.
- sdo is 0 whenever sh_en=0.

Decomposition:
- Shared package fsm_tx_pkg:
  - state encoding localparams (IDLE=3'd0, PRE=3'd1, GAP=3'd2, SHIFT=3'd3, TAIL=3'd4);
  - a counter-width helper function.
- One natural sub-module, frame_piso:
  - a DATA_W-bit parallel-in/serial-out register with load and shift enables, MSB out, asynchronous active-low clear;
  - the FSM plus counter stay in fsm_frame_tx.

Test Plan:
- Single frame (defaults), din=8'hA5, start pulsed at cycle 0 → rfout=1 in cycles 1-2; GAP in cycle 3; sh_en=1 in cycles 4-11 with sdo=1,0,1,0,0,1,0,1; done=1 in cycle 12 only; busy=1 in cycles 1-12.
- GAP_LEN=0, PRE_LEN=1, din=8'hFF → rfout in cycle 1; sh_en in cycles 2-9 with sdo all 1; done in cycle 10.
- start held high continuously, din=8'h3C then 8'hC3 → second frame's PRE begins in cycle 14 (one IDLE cycle after the cycle-12 done). Each frame serialises the din present at its own accept edge. Starts during busy cause no extra captures.
- rst_n driven low during SHIFT (cycle 7) → all outputs 0 asynchronously, before the next clock. After release, busy=0 until a new start, and the frame restarts cleanly from PRE.
- din changed to 8'h00 during PRE/SHIFT of a frame launched with 8'h81 → sdo still 1,0,0,0,0,0,0,1.
- Loop back with the receive synchroniser (rfin=rfout, sh_en shared) → receiver state rises after the rfout pulse and returns to IDLE on the cycle after TAIL.

Source files
------------

// File: rtl/fsm_tx_pkg.sv
// Shared definitions for the frame transmitter: state encoding and counter sizing.
// No logic of its own; imported by the FSM and its serialiser.
package fsm_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        GAP   = 3'd2,
        SHIFT = 3'd3,
        TAIL  = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/frame_piso.sv
// Parallel-in/serial-out register, MSB first, zero fill; load has priority over shift.
// Zero latency from register to msb; no backpressure, shifts whenever shift is high.
module frame_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/fsm_frame_tx.sv
// Wake pulse, gap, then framed MSB-first serial word; done pulses in the one TAIL cycle.
// First PRE cycle one clock after accepted start; start while busy is dropped, never queued.
module fsm_frame_tx
    import fsm_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRE_LEN = 2,
    parameter int GAP_LEN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              rfout,
    output logic              sh_en,
    output logic              sdo,
    output logic              done
);

    localparam int CW = cnt_width(PRE_LEN, GAP_LEN, DATA_W);
    localparam logic [CW-1:0] PRE_LD = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] GAP_LD = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [CW-1:0] DAT_LD = CW'(DATA_W - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;
    logic          msb;

    assign load  = (state == IDLE) && start;
    assign shift = (state == SHIFT);

    frame_piso #(.W(DATA_W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (din),
        .msb   (msb)
    );

    // Gating by the registered frame keeps sdo quiet outside SHIFT.
    assign sdo = sh_en & msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            rfout <= 1'b0;
            sh_en <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PRE;
                        cnt   <= PRE_LD;
                        busy  <= 1'b1;
                        rfout <= 1'b1;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        rfout <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state <= GAP;
                            cnt   <= GAP_LD;
                        end else begin
                            state <= SHIFT;
                            cnt   <= DAT_LD;
                            sh_en <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= SHIFT;
                        cnt   <= DAT_LD;
                        sh_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state <= TAIL;
                        sh_en <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TAIL: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rfout <= 1'b0;
                    sh_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
